dice_turn_ctrl: RTL

DICE_TURN_CTRL -- requirements
Module: dice_turn_ctrl

---
 rtl/dice_turn_ctrl_pkg.sv | 26 ++
 rtl/dice_turn_ctrl_btn_sync_edge.sv | 41 ++++
 rtl/dice_turn_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/dice_turn_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dice_turn_ctrl_pkg : state encoding, winner codes, die-face mapping  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dice_turn_ctrl_pkg;

  localparam int         c_state_w  = 3;
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_wait  = 3'd1;
  localparam logic [2:0] c_st_roll  = 3'd2;
  localparam logic [2:0] c_st_move  = 3'd3;
  localparam logic [2:0] c_st_check = 3'd4;
  localparam logic [2:0] c_st_over  = 3'd5;

  localparam logic [1:0] c_win_none = 2'b00;
  localparam logic [1:0] c_win_p1   = 2'b01;
  localparam logic [1:0] c_win_p2   = 2'b10;

  // rnd 0..5 maps onto faces 1..6; the two spare codes fold onto face 1
  function automatic logic [2:0] face_of(input logic [2:0] r);
    return (r <= 3'd5) ? r + 3'd1 : 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dice_turn_ctrl_btn_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_sync_edge : 2-flop synchronizer plus rising-edge pulse detector  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       r_armed;
  logic [1:0] r_warm;

  // A button already high when reset releases must be seen low before it
  // can produce a pulse, so r_armed waits until the synchronizer carries
  // real post-reset samples and then for a low level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_armed <= 1'b0;
      r_warm  <= 2'd0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      if (r_warm == 2'd2 && !r_s2) r_armed <= 1'b1;
    end
  end

  assign pulse = r_s2 & ~r_s3 & r_armed;

endmodule
`default_nettype wire

// File: rtl/dice_turn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dice_turn_ctrl : two-player dice race, turn sequencing and scoring   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dice_turn_ctrl
  import dice_turn_ctrl_pkg::*;
#(
  parameter int STEP  = 10,
  parameter int GOAL  = 700,
  parameter int POS_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             trig1,
  input  logic             trig2,
  input  logic [2:0]       rnd,
  output logic [2:0]       die1,
  output logic [2:0]       die2,
  output logic [POS_W-1:0] p1_pos,
  output logic [POS_W-1:0] p2_pos,
  output logic             turn,
  output logic             playing,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam logic [POS_W:0] c_step = (POS_W+1)'(STEP);
  localparam logic [POS_W:0] c_goal = (POS_W+1)'(GOAL);

  logic                 w_start_p;
  logic                 w_trig1_p;
  logic                 w_trig2_p;
  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_next;
  logic [POS_W-1:0]     w_cur_pos;
  logic [2:0]           w_face;
  logic [POS_W:0]       w_sum;
  logic [POS_W-1:0]     w_new_pos;
  logic                 w_at_goal;

  btn_sync_edge u_sync_start (.clk(clk), .reset(reset), .btn(start), .pulse(w_start_p));
  btn_sync_edge u_sync_trig1 (.clk(clk), .reset(reset), .btn(trig1), .pulse(w_trig1_p));
  btn_sync_edge u_sync_trig2 (.clk(clk), .reset(reset), .btn(trig2), .pulse(w_trig2_p));

  // The die written in ROLL doubles as the face register for MOVE.
  assign w_cur_pos = turn ? p2_pos : p1_pos;
  assign w_face    = turn ? die2 : die1;
  assign w_sum     = {1'b0, w_cur_pos} + c_step * {{(POS_W-2){1'b0}}, w_face};
  assign w_new_pos = (w_sum >= c_goal) ? c_goal[POS_W-1:0] : w_sum[POS_W-1:0];
  assign w_at_goal = ({1'b0, w_cur_pos} >= c_goal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle, c_st_over: if (w_start_p) w_next = c_st_wait;
      c_st_wait:  if (turn ? w_trig2_p : w_trig1_p) w_next = c_st_roll;
      c_st_roll:  w_next = c_st_move;
      c_st_move:  w_next = c_st_check;
      c_st_check: w_next = w_at_goal ? c_st_over : c_st_wait;
      default:    w_next = c_st_idle;
    endcase
  end

  always_comb begin
    playing   = 1'b0;
    game_over = 1'b0;
    case (r_state)
      c_st_wait, c_st_roll, c_st_move, c_st_check: playing = 1'b1;
      c_st_over: game_over = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_pos <= '0;
      p2_pos <= '0;
      die1   <= 3'd1;
      die2   <= 3'd1;
      turn   <= 1'b0;
      winner <= c_win_none;
    end else begin
      case (r_state)
        c_st_idle, c_st_over: begin
          if (w_start_p) begin
            p1_pos <= '0;
            p2_pos <= '0;
            die1   <= 3'd1;
            die2   <= 3'd1;
            turn   <= 1'b0;
            winner <= c_win_none;
          end
        end
        c_st_roll: begin
          if (turn) die2 <= face_of(rnd);
          else      die1 <= face_of(rnd);
        end
        c_st_move: begin
          if (turn) p2_pos <= w_new_pos;
          else      p1_pos <= w_new_pos;
        end
        c_st_check: begin
          if (w_at_goal) winner <= turn ? c_win_p2 : c_win_p1;
          else           turn   <= ~turn;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
